// File: rtl/onehot_fifo_ctrl.sv
// Buffer-slot controller: one-hot write/read pointers, entry count and valid/ready handshake.
// Optional level/almost_full outputs exist when ONEHOT_FIFO_CTRL_LEVEL_EN is defined.
module onehot_fifo_ctrl #(
   parameter int unsigned BUFFER_DEPTH = 8,
   parameter int unsigned AF_THRESH    = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BUFFER_DEPTH-1:0]       write_pointer,
   output logic [BUFFER_DEPTH-1:0]       read_pointer
`ifdef ONEHOT_FIFO_CTRL_LEVEL_EN
   ,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0] level,
   output logic                          almost_full
`endif
);

   localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);
   localparam logic [CW-1:0] C_FULL = CW'(BUFFER_DEPTH);
   localparam logic [BUFFER_DEPTH-1:0] C_PTR_INIT = BUFFER_DEPTH'(1);

   logic [BUFFER_DEPTH-1:0] r_wr_ptr;
   logic [BUFFER_DEPTH-1:0] r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic [CW-1:0]           w_count_nxt;
   logic                    r_not_full;
   logic                    r_not_empty;
   logic                    w_push;
   logic                    w_pop;

   // Handshake flags come from registered state; rst/flush only mask them so
   // no transfer can be accepted in a cycle that is about to be discarded.
   assign in_ready  = r_not_full  & ~flush & ~rst;
   assign out_valid = r_not_empty & ~flush & ~rst;
   assign w_push    = in_valid  & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign write_pointer = r_wr_ptr;
   assign read_pointer  = r_rd_ptr;

   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= C_PTR_INIT;
         r_rd_ptr    <= C_PTR_INIT;
         r_count     <= '0;
         r_not_full  <= 1'b1;
         r_not_empty <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_not_full  <= (w_count_nxt != C_FULL);
         r_not_empty <= (w_count_nxt != '0);
         if (flush) begin
            r_wr_ptr <= C_PTR_INIT;
            r_rd_ptr <= C_PTR_INIT;
         end else begin
            if (w_push) r_wr_ptr <= {r_wr_ptr[BUFFER_DEPTH-2:0], r_wr_ptr[BUFFER_DEPTH-1]};
            if (w_pop)  r_rd_ptr <= {r_rd_ptr[BUFFER_DEPTH-2:0], r_rd_ptr[BUFFER_DEPTH-1]};
         end
      end
   end

`ifdef ONEHOT_FIFO_CTRL_LEVEL_EN
   localparam logic [CW-1:0] C_AF = CW'(AF_THRESH);
   logic r_almost_full;

   always_ff @(posedge clk) begin
      if (rst) r_almost_full <= 1'b0;
      else     r_almost_full <= (w_count_nxt >= C_AF);
   end

   assign level       = r_count;
   assign almost_full = r_almost_full;
`endif

endmodule
